// File: rtl/rd_buffer_readout.sv
`default_nettype none
// ============================================================================
//  Module   : rd_buffer_readout
//  Purpose  : Reads one full RD capture buffer out of the capture BRAM
//             (port B) and streams it over an AXI-Stream style handshake,
//             then releases the buffer back to the capture stage.
//  Revision : 1.0  - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NWORDS      words per buffer (power of 2, <= 2048)
//    MEM_LATENCY BRAM read latency in cycles (1 or 2)
//    BUSY_WAIT   max cycles to wait for a busy buffer to become full
//    SKID_DEPTH  output FIFO depth (>= MEM_LATENCY+2)
//  Ports
//    CLK120, RST          clock, synchronous active-high reset
//    START, BUF_RNUM      one-cycle request and the buffer it targets
//    BUF_FULL, BUF_BUSY   per-buffer flags from the capture stage
//    MEM_EN/ADDR/DOUT     BRAM port-B read interface (byte address)
//    M_TDATA/TVALID/TREADY/TLAST  output stream
//    BUF_RELEASE, RELEASE_NUM     one-cycle release of a drained buffer
//    DONE, RESULT         end-of-request pulse and its code (0 OK,
//                         1 EMPTY, 2 TIMEOUT)
//    BUSY                 high whenever a request is in progress
// ============================================================================
module rd_buffer_readout #(
  parameter int NWORDS      = 2048,
  parameter int MEM_LATENCY = 1,
  parameter int BUSY_WAIT   = 1200,
  parameter int SKID_DEPTH  = 4
) (
  input  logic        CLK120,
  input  logic        RST,
  input  logic        START,
  input  logic [1:0]  BUF_RNUM,
  input  logic [3:0]  BUF_FULL,
  input  logic [3:0]  BUF_BUSY,
  output logic        MEM_EN,
  output logic [14:0] MEM_ADDR,
  input  logic [31:0] MEM_DOUT,
  output logic [31:0] M_TDATA,
  output logic        M_TVALID,
  input  logic        M_TREADY,
  output logic        M_TLAST,
  output logic        BUF_RELEASE,
  output logic [1:0]  RELEASE_NUM,
  output logic        DONE,
  output logic [1:0]  RESULT,
  output logic        BUSY
);

  localparam int C_WW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int C_PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int C_CW = $clog2(SKID_DEPTH + 1);
  localparam int C_SW = C_CW + 1;
  localparam int C_TW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;

  localparam logic [C_WW-1:0] C_LAST_WORD = C_WW'(NWORDS - 1);
  localparam logic [C_TW-1:0] C_WAIT_LAST = C_TW'(BUSY_WAIT - 1);
  localparam logic [C_PW-1:0] C_PTR_LAST  = C_PW'(SKID_DEPTH - 1);
  localparam logic [C_SW-1:0] C_DEPTH     = C_SW'(SKID_DEPTH);

  localparam logic [1:0] C_RES_OK      = 2'd0;
  localparam logic [1:0] C_RES_EMPTY   = 2'd1;
  localparam logic [1:0] C_RES_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_WAIT    = 3'd2,
    S_STREAM  = 3'd3,
    S_RELEASE = 3'd4,
    S_FINISH  = 3'd5
  } state_t;

  state_t            r_state;
  logic [1:0]        r_buf;
  logic [C_TW-1:0]   r_wait_cnt;
  logic [C_WW-1:0]   r_rw;        // next word to read
  logic              r_rd_done;   // all NWORDS reads issued
  logic [C_WW-1:0]   r_ow;        // index of word at the FIFO head
  logic              r_release;
  logic [1:0]        r_relnum;
  logic              r_done;
  logic [1:0]        r_result;
  logic              r_busy;

  // Read-return tracking and skid FIFO
  logic [MEM_LATENCY-1:0] r_vpipe;
  logic [C_CW-1:0]        r_outst;
  logic [31:0]            r_mem [SKID_DEPTH];
  logic [C_PW-1:0]        r_wp;
  logic [C_PW-1:0]        r_rp;
  logic [C_CW-1:0]        r_count;

  logic              w_fifo_valid;
  logic              w_pop;
  logic              w_push;
  logic [C_SW-1:0]   w_inflight;
  logic              w_issue;
  logic              w_last_beat;
  logic [10:0]       w_word11;

  function automatic logic [C_PW-1:0] ptr_inc(input logic [C_PW-1:0] p);
    return (p == C_PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign w_fifo_valid = (r_count != '0);
  assign w_pop        = w_fifo_valid && M_TREADY;
  assign w_push       = r_vpipe[MEM_LATENCY-1];
  // Reads in flight plus words already buffered; a new read is only issued
  // when its data is guaranteed a free FIFO slot on return.
  assign w_inflight   = C_SW'(r_outst) + C_SW'(r_count);
  assign w_issue      = (r_state == S_STREAM) && !r_rd_done && (w_inflight < C_DEPTH);
  assign w_last_beat  = (r_ow == C_LAST_WORD);
  assign w_word11     = 11'(r_rw);

  assign MEM_EN      = w_issue;
  assign MEM_ADDR    = w_issue ? {r_buf, w_word11, 2'b00} : 15'd0;
  assign M_TVALID    = w_fifo_valid;
  assign M_TDATA     = w_fifo_valid ? r_mem[r_rp] : 32'd0;
  assign M_TLAST     = w_fifo_valid && w_last_beat;
  assign BUF_RELEASE = r_release;
  assign RELEASE_NUM = r_relnum;
  assign DONE        = r_done;
  assign RESULT      = r_result;
  assign BUSY        = r_busy;

  // Control FSM; all request-level outputs are registered here.
  always_ff @(posedge CLK120) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_buf      <= '0;
      r_wait_cnt <= '0;
      r_rw       <= '0;
      r_rd_done  <= 1'b0;
      r_ow       <= '0;
      r_release  <= 1'b0;
      r_relnum   <= '0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_release <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_buf   <= BUF_RNUM;
            r_busy  <= 1'b1;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          r_rw      <= '0;
          r_rd_done <= 1'b0;
          r_ow      <= '0;
          if (BUF_FULL[r_buf]) begin
            r_state <= S_STREAM;
          end else if (BUF_BUSY[r_buf]) begin
            r_wait_cnt <= '0;
            r_state    <= S_WAIT;
          end else begin
            r_result <= C_RES_EMPTY;
            r_done   <= 1'b1;
            r_state  <= S_FINISH;
          end
        end
        S_WAIT: begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
          // FULL wins over the timeout when both happen in the same cycle.
          if (BUF_FULL[r_buf]) begin
            r_state <= S_STREAM;
          end else if (r_wait_cnt == C_WAIT_LAST) begin
            r_result <= C_RES_TIMEOUT;
            r_done   <= 1'b1;
            r_state  <= S_FINISH;
          end
        end
        S_STREAM: begin
          // FULL is not re-checked here: once started, the buffer drains.
          if (w_issue) begin
            r_rw <= r_rw + 1'b1;
            if (r_rw == C_LAST_WORD) begin
              r_rd_done <= 1'b1;
            end
          end
          if (w_pop) begin
            r_ow <= r_ow + 1'b1;
            if (w_last_beat) begin
              r_release <= 1'b1;
              r_relnum  <= r_buf;
              r_result  <= C_RES_OK;
              r_state   <= S_RELEASE;
            end
          end
        end
        S_RELEASE: begin
          r_done  <= 1'b1;
          r_state <= S_FINISH;
        end
        S_FINISH: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Return-valid pipeline matching the BRAM latency, outstanding-read count
  // and FIFO pointers. Clearing r_vpipe on reset drops any read still in
  // flight so an abandoned stream cannot leak into the next one.
  always_ff @(posedge CLK120) begin
    if (RST) begin
      r_vpipe <= '0;
      r_outst <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      r_vpipe[0] <= w_issue;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        r_vpipe[i] <= r_vpipe[i-1];
      end

      case ({w_issue, w_push})
        2'b10:   r_outst <= r_outst + 1'b1;
        2'b01:   r_outst <= r_outst - 1'b1;
        default: r_outst <= r_outst;
      endcase

      if (w_push) begin
        r_wp <= ptr_inc(r_wp);
      end
      if (w_pop) begin
        r_rp <= ptr_inc(r_rp);
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage needs no reset; r_count gates every read of it.
  always_ff @(posedge CLK120) begin
    if (w_push) begin
      r_mem[r_wp] <= MEM_DOUT;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rd_buffer_readout.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rd_buffer_readout
//  Purpose  : Directed self-checking bench for rd_buffer_readout. Two DUTs
//             (MEM_LATENCY 1 and 2) share all stimulus; each has its own
//             BRAM model whose contents equal the byte address.
//  Revision : 1.0  - initial release
// ============================================================================
module tb_rd_buffer_readout;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, ready;
  logic [1:0] rnum;
  logic [3:0] full, bbusy;

  logic        en_a, tv_a, tl_a, rel_a, dn_a, bz_a;
  logic [14:0] ad_a;
  logic [31:0] td_a, dout_a;
  logic [1:0]  rn_a, rs_a;

  logic        en_b, tv_b, tl_b, rel_b, dn_b, bz_b;
  logic [14:0] ad_b;
  logic [31:0] td_b, dout_b, lat2_r;
  logic [1:0]  rn_b, rs_b;

  rd_buffer_readout #(.NWORDS(2048), .MEM_LATENCY(1), .BUSY_WAIT(1200), .SKID_DEPTH(4)) dut_a (
    .CLK120(clk), .RST(rst), .START(start), .BUF_RNUM(rnum),
    .BUF_FULL(full), .BUF_BUSY(bbusy),
    .MEM_EN(en_a), .MEM_ADDR(ad_a), .MEM_DOUT(dout_a),
    .M_TDATA(td_a), .M_TVALID(tv_a), .M_TREADY(ready), .M_TLAST(tl_a),
    .BUF_RELEASE(rel_a), .RELEASE_NUM(rn_a), .DONE(dn_a), .RESULT(rs_a), .BUSY(bz_a)
  );

  rd_buffer_readout #(.NWORDS(2048), .MEM_LATENCY(2), .BUSY_WAIT(1200), .SKID_DEPTH(4)) dut_b (
    .CLK120(clk), .RST(rst), .START(start), .BUF_RNUM(rnum),
    .BUF_FULL(full), .BUF_BUSY(bbusy),
    .MEM_EN(en_b), .MEM_ADDR(ad_b), .MEM_DOUT(dout_b),
    .M_TDATA(td_b), .M_TVALID(tv_b), .M_TREADY(ready), .M_TLAST(tl_b),
    .BUF_RELEASE(rel_b), .RELEASE_NUM(rn_b), .DONE(dn_b), .RESULT(rs_b), .BUSY(bz_b)
  );

  // BRAM models: memory word at byte address A holds A.
  always @(posedge clk) begin
    if (en_a) dout_a <= {17'd0, ad_a};
  end
  always @(posedge clk) begin
    if (en_b) lat2_r <= {17'd0, ad_b};
    dout_b <= lat2_r;
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_on, forbid, rmode;
  logic [1:0] exp_buf;

  // Per-instance sampled outputs (index 0 = latency 1, 1 = latency 2)
  logic [1:0]  s_en, s_tv, s_tl, s_rel, s_dn, s_bz;
  logic [14:0] s_ad [2];
  logic [31:0] s_td [2];
  logic [1:0]  s_rn [2];
  logic [1:0]  s_rs [2];

  // Per-instance scoreboard
  int         iss [2];
  int         beats [2];
  int         rel_cnt [2];
  int         done_cnt [2];
  int         first_en [2];
  int         first_v [2];
  int         last_cyc [2];
  int         rel_cyc [2];
  int         done_cyc [2];
  logic [1:0] done_res [2];
  bit         stall_prev [2];
  logic [31:0] prev_td [2];
  logic       prev_tl [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mon_reset();
    for (int i = 0; i < 2; i++) begin
      iss[i] = 0; beats[i] = 0; rel_cnt[i] = 0; done_cnt[i] = 0;
      first_en[i] = -1; first_v[i] = -1; last_cyc[i] = -1;
      rel_cyc[i] = -1; done_cyc[i] = -1; done_res[i] = 2'd3;
      stall_prev[i] = 1'b0; prev_td[i] = '0; prev_tl[i] = 1'b0;
    end
  endtask

  task automatic sample();
    s_en = {en_b, en_a}; s_tv = {tv_b, tv_a}; s_tl = {tl_b, tl_a};
    s_rel = {rel_b, rel_a}; s_dn = {dn_b, dn_a}; s_bz = {bz_b, bz_a};
    s_ad[0] = ad_a; s_ad[1] = ad_b; s_td[0] = td_a; s_td[1] = td_b;
    s_rn[0] = rn_a; s_rn[1] = rn_b; s_rs[0] = rs_a; s_rs[1] = rs_b;
  endtask

  task automatic mon(input int i);
    logic [31:0] idx;
    logic [14:0] eaddr;
    logic        ok;
    if (!mon_on) return;
    if (forbid) chk("forbid_en_tv_rel", {s_en[i], s_tv[i], s_rel[i]}, 0);
    if (s_en[i]) begin
      if (first_en[i] < 0) first_en[i] = cyc;
      idx = iss[i];
      eaddr = {exp_buf, idx[10:0], 2'b00};
      chk("mem_addr", s_ad[i], eaddr);
      chk("read_in_range", (iss[i] < 2048) ? 1 : 0, 1);
      iss[i]++;
    end
    if (s_en[i] || s_tv[i]) begin
      ok = ((iss[i] - beats[i]) <= 4);
      chk("inflight_le_depth", ok, 1);
    end
    if (stall_prev[i]) chk("stall_hold", {s_tv[i], s_tl[i], s_td[i]}, {1'b1, prev_tl[i], prev_td[i]});
    if (s_tv[i]) begin
      if (first_v[i] < 0) first_v[i] = cyc;
      if (ready) begin
        idx = beats[i];
        chk("tdata", s_td[i], {17'd0, exp_buf, idx[10:0], 2'b00});
        chk("tlast", s_tl[i], (beats[i] == 2047) ? 1 : 0);
        if (beats[i] == 2047) last_cyc[i] = cyc;
        beats[i]++;
      end
    end
    stall_prev[i] = s_tv[i] && !ready;
    prev_td[i] = s_td[i];
    prev_tl[i] = s_tl[i];
    if (s_rel[i]) begin
      rel_cnt[i]++;
      rel_cyc[i] = cyc;
      chk("release_num", s_rn[i], exp_buf);
      chk("release_after_all_beats", beats[i], 2048);
    end
    if (s_dn[i]) begin
      done_cnt[i]++;
      done_cyc[i] = cyc;
      done_res[i] = s_rs[i];
    end
  endtask

  // One clock: inputs change and outputs are observed on the falling edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
    sample();
    mon(0);
    mon(1);
  endtask

  task automatic run_until_done(input int budget, input string tag);
    int n;
    n = 0;
    while (!(done_cnt[0] > 0 && done_cnt[1] > 0) && n < budget) begin
      tick();
      n++;
    end
    chk(tag, (done_cnt[0] > 0 && done_cnt[1] > 0) ? 1 : 0, 1);
  endtask

  task automatic chk_zero(input string tag);
    sample();
    for (int i = 0; i < 2; i++) begin
      chk(tag, {s_en[i], s_ad[i], s_td[i], s_tv[i], s_tl[i], s_rel[i],
                s_rn[i], s_dn[i], s_rs[i], s_bz[i]}, 0);
    end
  endtask

  task automatic check_stream(input bit strict, input int entry_cyc);
    for (int i = 0; i < 2; i++) begin
      chk("beats", beats[i], 2048);
      chk("reads", iss[i], 2048);
      chk("release_count", rel_cnt[i], 1);
      chk("done_count", done_cnt[i], 1);
      chk("result_ok", done_res[i], 0);
      chk("stream_entry", first_en[i], entry_cyc);
      chk("fill_latency", first_v[i] - first_en[i], i + 2);
      chk("release_after_tlast", rel_cyc[i] - last_cyc[i], 1);
      chk("done_after_release", done_cyc[i] - rel_cyc[i], 1);
      if (strict) chk("zero_bubble", last_cyc[i] - first_v[i], 2047);
    end
  endtask

  initial begin
    int k;
    int n;
    rst = 1'b1; start = 1'b0; rnum = 2'd0; full = 4'd0; bbusy = 4'd0;
    ready = 1'b1; rmode = 1'b0; mon_on = 1'b0; forbid = 1'b0; exp_buf = 2'd0;
    mon_reset();
    repeat (3) tick();
    chk_zero("reset_outputs");
    rst = 1'b0;
    tick();

    // Full buffer 2, ready always high
    full = 4'b0100; exp_buf = 2'd2; mon_reset(); mon_on = 1'b1;
    rnum = 2'd2; k = cyc; start = 1'b1; tick(); start = 1'b0;
    run_until_done(3000, "t1_done_reached");
    check_stream(1'b1, k + 2);
    tick();
    chk("t1_busy_low", s_bz, 2'b00);

    // Same buffer with a randomly stalling consumer
    rmode = 1'b1; mon_reset();
    k = cyc; start = 1'b1; tick(); start = 1'b0;
    run_until_done(12000, "t2_done_reached");
    check_stream(1'b0, k + 2);
    rmode = 1'b0;
    repeat (2) tick();

    // Buffer 1 neither full nor busy: EMPTY, no traffic
    full = 4'd0; bbusy = 4'd0; forbid = 1'b1; mon_reset();
    rnum = 2'd1; k = cyc; start = 1'b1; tick(); start = 1'b0;
    run_until_done(20, "t3_done_reached");
    repeat (5) tick();
    for (int i = 0; i < 2; i++) begin
      chk("t3_done_time", done_cyc[i] - k, 2);
      chk("t3_result_empty", done_res[i], 1);
      chk("t3_done_count", done_cnt[i], 1);
      chk("t3_no_release", rel_cnt[i], 0);
      chk("t3_no_reads", iss[i], 0);
    end
    forbid = 1'b0;

    // Buffer 3 busy, becomes full 500 cycles after START
    bbusy = 4'b1000; forbid = 1'b1; exp_buf = 2'd3; mon_reset();
    rnum = 2'd3; start = 1'b1; tick(); start = 1'b0;
    repeat (499) tick();
    chk("t4_no_done_while_waiting", done_cnt[0] + done_cnt[1], 0);
    forbid = 1'b0; full = 4'b1000; k = cyc;
    run_until_done(3000, "t4_done_reached");
    check_stream(1'b1, k + 1);
    full = 4'd0; bbusy = 4'd0;
    repeat (2) tick();

    // Buffer 0 busy forever: TIMEOUT after 1200 wait cycles
    bbusy = 4'b0001; forbid = 1'b1; mon_reset();
    rnum = 2'd0; k = cyc; start = 1'b1; tick(); start = 1'b0;
    run_until_done(1400, "t5_done_reached");
    for (int i = 0; i < 2; i++) begin
      // CHECK at k+1, WAIT from k+2 for 1200 cycles, FINISH at k+1202
      chk("t5_done_time", done_cyc[i] - k, 1202);
      chk("t5_result_timeout", done_res[i], 2);
      chk("t5_no_release", rel_cnt[i], 0);
    end
    tick();
    chk("t5_busy_low", s_bz, 2'b00);
    forbid = 1'b0; bbusy = 4'd0;

    // Reset after 100 beats, then a clean full request on buffer 0
    full = 4'b0001; exp_buf = 2'd0; mon_reset();
    rnum = 2'd0; start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (beats[0] < 100 && n < 500) begin
      tick();
      n++;
    end
    chk("t6_reached_100_beats", (beats[0] >= 100) ? 1 : 0, 1);
    rst = 1'b1; mon_on = 1'b0;
    tick();
    chk_zero("t6_mid_reset_outputs");
    rst = 1'b0;
    tick();
    mon_reset(); mon_on = 1'b1;
    k = cyc; start = 1'b1; tick(); start = 1'b0;
    repeat (49) tick();
    rnum = 2'd2; start = 1'b1; tick(); start = 1'b0; rnum = 2'd0;
    run_until_done(3000, "t6_done_reached");
    check_stream(1'b1, k + 2);
    repeat (10) tick();
    for (int i = 0; i < 2; i++) begin
      chk("t6_single_done", done_cnt[i], 1);
    end
    chk("t6_busy_low", s_bz, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
